// File: rtl/ro_tile_pkg.sv
// Shared types and constants for the ring-oscillator TDC tile: sequencer
// state encoding plus channel, count and byte widths.
package ro_tile_pkg;

    localparam int NCH    = 8;
    localparam int CNT_W  = 19;
    localparam int SEL_W  = 3;
    localparam int BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        FIND,
        PREP,
        RUN,
        HOLD,
        CAP,
        TX0,
        TX1,
        TX2,
        DONE
    } ro_state_e;

endpackage

// File: rtl/ro_prio_find.sv
// Combinational finder: lowest set bit of mask at or above base.
// found=0 when no enabled channel exists in [base, NCH-1].
module ro_prio_find
    import ro_tile_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] base,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Walk downward so the lowest qualifying channel is the last write.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (SEL_W'(i) >= base)) begin
                found = 1'b1;
                idx   = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/ro_scan_ctrl.sv
// Ring-oscillator scan sequencer: gates each enabled RO channel in turn,
// captures its count and streams it out as three bytes.
module ro_scan_ctrl
    import ro_tile_pkg::*;
#(
    parameter int GATE_W = 16,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [NCH-1:0]    ch_mask,
    input  logic [GATE_W-1:0] gate_len,
    output logic              ro_activate,
    output logic              ro_deactivate,
    output logic [SEL_W-1:0]  ro_sel,
    input  logic [CNT_W-1:0]  ro_count,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output ro_state_e         state_dbg
);

    ro_state_e         state, ns;
    logic [NCH-1:0]    mask_q;
    logic [GATE_W-1:0] gate_q, tmr_q;
    logic [SEL_W-1:0]  idx_q, idx_d, idx_inc, fa_idx, fb_idx;
    logic [CNT_W-1:0]  cnt_q;
    logic [BYTE_W-1:0] data_d;
    logic [2:0]        cnt_hi;
    logic              fa_found, fb_found, more, start_ok, xfer;

    assign state_dbg = state;
    assign idx_inc   = idx_q + SEL_W'(1);
    assign start_ok  = (state == IDLE) && start && !abort;
    // Byte handshake: a byte moves on any cycle with out_valid & out_ready;
    // while stalled, out_data/out_last/out_valid hold their values.
    assign xfer      = out_valid && out_ready;
    // The top channel has nothing above it; idx_inc would wrap to 0.
    assign more      = fb_found && (idx_q != SEL_W'(NCH - 1));

    ro_prio_find u_find_cur (
        .mask  (mask_q),
        .base  (idx_q),
        .found (fa_found),
        .idx   (fa_idx)
    );

    ro_prio_find u_find_next (
        .mask  (mask_q),
        .base  (idx_inc),
        .found (fb_found),
        .idx   (fb_idx)
    );

    always_comb begin
        ns    = state;
        idx_d = idx_q;
        case (state)
            IDLE: if (start_ok) begin ns = FIND; idx_d = '0; end
            FIND: if (fa_found) begin ns = PREP; idx_d = fa_idx; end
                  else ns = DONE;
            PREP: ns = RUN;
            RUN:  if (tmr_q <= GATE_W'(1)) ns = HOLD;
            HOLD: if (tmr_q <= GATE_W'(1)) ns = CAP;
            CAP:  ns = TX0;
            TX0:  if (xfer) ns = TX1;
            TX1:  if (xfer) ns = TX2;
            TX2:  if (xfer) begin
                      if (more) begin ns = FIND; idx_d = idx_inc; end
                      else ns = DONE;
                  end
            DONE: ns = IDLE;
            default: ns = IDLE;
        endcase
        if (abort && (state != IDLE) && (state != DONE)) begin
            ns    = DONE;
            idx_d = idx_q;
        end
    end

    // The first byte leaves in the same edge that latches the count.
    assign cnt_hi = (state == CAP) ? ro_count[CNT_W-1:16] : cnt_q[CNT_W-1:16];

    always_comb begin
        data_d = '0;
        case (ns)
            TX0:     data_d = {idx_d, 2'b00, cnt_hi};
            TX1:     data_d = cnt_q[15:8];
            TX2:     data_d = cnt_q[7:0];
            default: data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx_q  <= '0;
            mask_q <= '0;
            gate_q <= '0;
            tmr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            state <= ns;
            idx_q <= idx_d;
            if (start_ok) begin
                mask_q <= ch_mask;
                gate_q <= gate_len;
            end
            // One timer serves the gate window and then the settle window.
            case (state)
                PREP: tmr_q <= (gate_q == '0) ? GATE_W'(1) : gate_q;
                RUN:  tmr_q <= (tmr_q <= GATE_W'(1)) ? GATE_W'(SETTLE) : tmr_q - GATE_W'(1);
                HOLD: tmr_q <= tmr_q - GATE_W'(1);
                default: tmr_q <= tmr_q;
            endcase
            if (state == CAP) cnt_q <= ro_count;
        end
    end

    // Outputs decode the next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            ro_activate   <= 1'b0;
            ro_deactivate <= 1'b1;
            ro_sel        <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            ro_activate   <= (ns == RUN);
            ro_deactivate <= (ns != RUN);
            ro_sel        <= idx_d;
            out_data      <= data_d;
            out_valid     <= (ns == TX0) || (ns == TX1) || (ns == TX2);
            out_last      <= (ns == TX2) && !more;
            busy          <= (ns != IDLE);
            done          <= (ns == DONE);
        end
    end

endmodule

// File: tb/tb_ro_scan_ctrl.sv
// Directed bench for ro_scan_ctrl: single, full, sparse and empty scans,
// backpressure, abort, mid-scan reset, zero gate and start-while-busy.
module tb_ro_scan_ctrl;
    import ro_tile_pkg::*;

    logic              clk = 1'b0;
    logic              rst, start, abort, out_ready;
    logic [7:0]        ch_mask;
    logic [15:0]       gate_len;
    logic              ro_activate, ro_deactivate, out_valid, out_last, busy, done;
    logic [2:0]        ro_sel;
    logic [18:0]       ro_count, fixed_cnt;
    logic [7:0]        out_data;
    ro_state_e         state_dbg;
    logic              use_model, bp_mode;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc, done_cyc, last_xfer_cyc;
    int act_cycles, act_rises, both_high, done_cnt, valid_cycles, stall_viol;
    logic [2:0] act_sel;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    assign ro_count = use_model ? 19'(int'(ro_sel) * 1000) : fixed_cnt;

    ro_scan_ctrl #(.GATE_W(16), .SETTLE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ch_mask(ch_mask), .gate_len(gate_len),
        .ro_activate(ro_activate), .ro_deactivate(ro_deactivate),
        .ro_sel(ro_sel), .ro_count(ro_count),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // 1-in-3 ready pattern, applied just after each rising edge
    initial begin : ready_drv
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #2;
            if (bp_mode) begin
                out_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
        end
    end

    // Monitor sampling on the falling edge
    initial begin : monitor
        logic prev_act, prev_v, prev_r, prev_l;
        logic [7:0] prev_d;
        prev_act = 0; prev_v = 0; prev_r = 0; prev_l = 0; prev_d = 0;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_data});
                last_xfer_cyc = cyc;
            end
            if (out_valid) valid_cycles++;
            if (ro_activate) begin act_cycles++; act_sel = ro_sel; end
            if (ro_activate && !prev_act) act_rises++;
            if (ro_activate && ro_deactivate) both_high++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (prev_v && !prev_r && !rst && !abort)
                if (!out_valid || out_data != prev_d || out_last != prev_l) stall_viol++;
            prev_act = ro_activate; prev_v = out_valid; prev_r = out_ready;
            prev_d = out_data; prev_l = out_last;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check1({tag, "_act"}, ro_activate, 1'b0);
        check1({tag, "_deact"}, ro_deactivate, 1'b1);
        check({tag, "_sel"}, 32'(ro_sel), 32'd0);
        check1({tag, "_valid"}, out_valid, 1'b0);
        check1({tag, "_last"}, out_last, 1'b0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        act_cycles = 0; act_rises = 0; both_high = 0; done_cnt = 0;
        valid_cycles = 0; stall_viol = 0; done_cyc = -1; last_xfer_cyc = -1;
        act_sel = 3'd0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check1({tag, "_done_seen"}, done, 1'b1);
        #1;
    endtask

    task automatic push_exp(input logic last, input logic [7:0] b);
        exp_q.push_back({last, b});
    endtask

    task automatic compare_bytes(input string tag);
        check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
                check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    // Start a scan at a falling edge, then scramble the config pins
    task automatic launch(input logic [7:0] m, input logic [15:0] g);
        clear_mon();
        ch_mask = m; gate_len = g; start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0; ch_mask = ~m; gate_len = g + 16'd7;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        ch_mask = 8'h00; gate_len = 16'd0; fixed_cnt = 19'h5A3C1;
        use_model = 1'b0; bp_mode = 1'b0;
        clear_mon();
        repeat (2) @(negedge clk);
        check_reset_vals("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_after");

        // Single channel 2, gate 10
        launch(8'h04, 16'd10);
        wait_done("single", 2000);
        push_exp(1'b0, 8'h45); push_exp(1'b0, 8'hA3); push_exp(1'b1, 8'hC1);
        compare_bytes("single");
        check("single_act_cycles", 32'(act_cycles), 32'd10);
        check("single_act_sel", 32'(act_sel), 32'd2);
        check("single_done_after_last", 32'(done_cyc - last_xfer_cyc), 32'd1);
        check("single_done_latency", 32'(done_cyc - start_cyc), 32'd21);
        @(negedge clk);
        check1("single_busy_low", busy, 1'b0);
        check1("single_done_pulse", done, 1'b0);

        // Full scan, count = channel*1000
        use_model = 1'b1;
        launch(8'hFF, 16'd3);
        wait_done("full", 4000);
        for (int ch = 0; ch < 8; ch++) begin
            logic [18:0] c;
            c = 19'(ch * 1000);
            push_exp(1'b0, {3'(ch), 2'b00, c[18:16]});
            push_exp(1'b0, c[15:8]);
            push_exp(ch == 7, c[7:0]);
        end
        compare_bytes("full");
        check("full_act_cycles", 32'(act_cycles), 32'd24);
        check("full_both_high", 32'(both_high), 32'd0);
        @(negedge clk);

        // Sparse mask 0x81
        launch(8'h81, 16'd2);
        wait_done("sparse", 2000);
        push_exp(1'b0, 8'h00); push_exp(1'b0, 8'h00); push_exp(1'b0, 8'h00);
        push_exp(1'b0, 8'hE0); push_exp(1'b0, 8'h1B); push_exp(1'b1, 8'h58);
        compare_bytes("sparse");
        @(negedge clk);

        // Empty mask
        launch(8'h00, 16'd5);
        wait_done("empty", 50);
        check("empty_done_latency", 32'(done_cyc - start_cyc), 32'd2);
        check("empty_valid_cycles", 32'(valid_cycles), 32'd0);
        check("empty_act_cycles", 32'(act_cycles), 32'd0);
        @(negedge clk);

        // Backpressure on channel 0, fixed count
        use_model = 1'b0;
        bp_mode = 1'b1;
        launch(8'h01, 16'd5);
        wait_done("bp", 2000);
        bp_mode = 1'b0;
        out_ready = 1'b1;
        push_exp(1'b0, 8'h05); push_exp(1'b0, 8'hA3); push_exp(1'b1, 8'hC1);
        compare_bytes("bp");
        check("bp_stall_viol", 32'(stall_viol), 32'd0);
        check("bp_act_rises", 32'(act_rises), 32'd1);
        check("bp_act_cycles", 32'(act_cycles), 32'd5);
        @(negedge clk);

        // Abort mid-RUN on channel 1
        use_model = 1'b1;
        launch(8'h03, 16'd20);
        begin
            int n;
            n = 0;
            while (!(ro_activate && ro_sel == 3'd1) && n < 500) begin
                @(negedge clk);
                n++;
            end
        end
        check1("abort_reached_ch1", ro_activate, 1'b1);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check1("abort_act_low", ro_activate, 1'b0);
        check1("abort_deact_high", ro_deactivate, 1'b1);
        check1("abort_done", done, 1'b1);
        check1("abort_valid_low", out_valid, 1'b0);
        @(negedge clk);
        #1;
        check1("abort_idle_busy", busy, 1'b0);
        push_exp(1'b0, 8'h00); push_exp(1'b0, 8'h00); push_exp(1'b0, 8'h00);
        compare_bytes("abort");
        check("abort_done_cnt", 32'(done_cnt), 32'd1);

        launch(8'h03, 16'd2);
        wait_done("post_abort", 2000);
        push_exp(1'b0, 8'h00); push_exp(1'b0, 8'h00); push_exp(1'b0, 8'h00);
        push_exp(1'b0, 8'h20); push_exp(1'b0, 8'h03); push_exp(1'b1, 8'hE8);
        compare_bytes("post_abort");
        @(negedge clk);

        // Reset during TX1
        use_model = 1'b0;
        launch(8'h01, 16'd2);
        begin
            int n;
            n = 0;
            while (state_dbg != TX1 && n < 500) begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_reached_tx1", 32'(state_dbg), 32'(TX1));
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_tx1");
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_reset_vals("rst_tx1_after");
        check("rst_no_done", 32'(done_cnt), 32'd0);

        // Zero gate, plus a start pulse while busy
        launch(8'h04, 16'd0);
        repeat (4) @(negedge clk);
        ch_mask = 8'hFF; gate_len = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", 2000);
        push_exp(1'b0, 8'h45); push_exp(1'b0, 8'hA3); push_exp(1'b1, 8'hC1);
        compare_bytes("busy_start");
        check("gate0_act_cycles", 32'(act_cycles), 32'd1);
        check("gate0_act_rises", 32'(act_rises), 32'd1);
        check("gate0_done_latency", 32'(done_cyc - start_cyc), 32'd12);
        @(negedge clk);
        check1("final_busy_low", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ro_scan_ctrl.md
Name: ro_scan_ctrl

Overview:
- Measurement sequencer for the 8-channel ring-oscillator TDC bank (8 ROs, 19-bit count each, 3-bit select).
- On `start`, visits each enabled channel in ascending order:
  - clears the channel, gates it for a programmed number of clk cycles, then stops it;
  - captures its 19-bit count and streams it out as 3 bytes over a valid/ready byte interface.
- Sits between the top-level IO (config pins / host) and the TDC datapath, and owns ro_activate, ro_deactivate and the channel select.

Parameters:
- GATE_W, 16, width of the gate-length input.
- SETTLE, 4, cycles ro_deactivate is held after the gate closes before capture (range 1..15).
- NCH, 8, number of RO channels (fixed; select width 3).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin scan; sampled only in IDLE.
- abort  in  1  terminate scan; priority over everything except rst.
- ch_mask  in  8  channel enable bitmap; bit i enables RO i.
- gate_len  in  GATE_W  gate length in clk cycles; 0 treated as 1.
- ro_activate  out  1  to TDC, RO enable.
- ro_deactivate  out  1  to TDC, RO clear/stop.
- ro_sel  out  3  to TDC, selects the channel count.
- ro_count  in  19  selected channel count from the TDC.
- out_data  out  8  byte stream data.
- out_valid  out  1  byte valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  marks final byte of the scan.
- busy  out  1  high from the cycle after start acceptance until DONE exits.
- done  out  1  1-cycle pulse at scan end, normal or aborted.

Behaviour:
- Reset values (while rst and the cycle after):
  - state=IDLE, ro_activate=0, ro_deactivate=1, ro_sel=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
  - All outputs are registered.
- Config capture: ch_mask and gate_len are latched on the start-accept cycle; later changes are ignored until the next scan.
- IDLE:
  - ro_deactivate=1, ro_activate=0.
  - start=1 -> FIND. If the latched mask is 0 -> DONE directly; no bytes are produced.
- FIND: the index register holds the lowest enabled channel >= current index. Index starts at 0. FIND takes 1 cycle -> PREP.
- PREP (1 cycle):
  - ro_sel=idx, ro_deactivate=1, ro_activate=0.
  - -> RUN.
- RUN:
  - ro_activate=1, ro_deactivate=0, for exactly max(gate_len,1) cycles, counted by a GATE_W down-counter.
  - -> HOLD.
- HOLD:
  - ro_activate=0, ro_deactivate=1, for SETTLE cycles.
  - ro_deactivate falling and rising edges drive the TDC's async buffer reset, so ro_activate and ro_deactivate are never high together.
  - -> CAP.
- CAP (1 cycle): latch ro_count into a 19-bit register -> TX0.
- TX0/TX1/TX2 each hold one byte with out_valid=1:
  - TX0 = {idx[2:0], 2'b00, cnt[18:16]}
  - TX1 = cnt[15:8]
  - TX2 = cnt[7:0]
- Handshake:
  - A transfer occurs on a cycle with out_valid & out_ready; the state advances on the next edge.
  - out_data, out_last and out_valid are stable while out_valid & !out_ready.
  - out_valid drops only after the TX2 transfer.
- out_last=1 only during TX2 of the highest enabled channel.
- After the TX2 transfer:
  - more enabled channels above idx -> FIND with idx+1;
  - else -> DONE.
- DONE (1 cycle): done=1, ro_deactivate=1 -> IDLE; busy low in the IDLE cycle.
- abort=1 in any non-IDLE state:
  - next cycle state=DONE; ro_activate=0, ro_deactivate=1, out_valid=0;
  - any partially sent channel is discarded, and no out_last is emitted.
- rst mid-scan: immediate return to reset values on the next edge; no done pulse.
- start while busy: ignored. start and abort together in IDLE: abort wins, start ignored.
- Wrap-around: idx never wraps past 7. ro_count saturation is the TDC's responsibility and is passed through unmodified.

Decomposition:
- Shared package `ro_tile_pkg`:
  - state enum (IDLE, FIND, PREP, RUN, HOLD, CAP, TX0, TX1, TX2, DONE);
  - constants NCH=8, CNT_W=19, SEL_W=3, BYTE_W=8.
- Sub-module `ro_prio_find`: combinational next-enabled-channel finder. Inputs: mask[7:0] and base idx. Outputs: found flag and next idx. Used in FIND, and for the "more channels" check after TX2.

Test Plan:
- Single channel: mask=8'h04, gate_len=10, ro_count tied to 19'h5A3C1, out_ready=1.
  - ro_activate high exactly 10 cycles with ro_sel=2.
  - Bytes 0x45, 0xA3, 0xC1; out_last on 0xC1.
  - done 1 cycle after the last byte; busy low on the following cycle.
- Full scan: mask=8'hFF, gate_len=3, ro_count model = channel*1000.
  - 24 bytes, channels ascending 0..7; channel 7 bytes 0xE0, 0x1B, 0x58; out_last only on the 24th byte.
- Sparse/empty masks:
  - mask=8'h81 -> channels 0 and 7 only, 6 bytes.
  - mask=0 -> done 2 cycles after start, no out_valid, ro_activate never high.
- Backpressure: out_ready toggled 1-in-3, mask=8'h01.
  - out_data stable under stall; exactly 3 transfers; gate does not restart.
- Abort: abort asserted mid-RUN on channel 1 (mask=8'h03).
  - ro_activate low and ro_deactivate high the next cycle; done pulse; no bytes for channel 1 and no out_last.
  - A following start scans correctly.
- Reset and edge cases:
  - rst asserted in TX1 -> all outputs at reset values next cycle, no done.
  - gate_len=0 -> 1-cycle gate.
  - start during busy -> no effect.
